mux_pack: RTL and testbench
===========================

# mux_pack

Byte-to-word packer on the return path of the decryption datapath, the counterpart of the input demux. It takes the SYS_DWIDTH character stream from the decryptor selected by `select` and reassembles MST_DWIDTH words, most-significant character first. This is the same lane order the demux uses when it unpacks words. It emits each word with a one-cycle valid pulse and supports flushing a partial word at end of message.

## Interface
- MST_DWIDTH, 32, packed output word width; must be an integer multiple of SYS_DWIDTH.
- SYS_DWIDTH, 8, character width on each decryptor channel.
- NBYTES (localparam), MST_DWIDTH/SYS_DWIDTH = 4, characters per word.
- CW (localparam), clog2(NBYTES)+1 = 3, width of the byte count.
- clk_sys  in  1  system clock. One clock; reset is asynchronous and active-low.
- rst_n  in  1  asynchronous active-low reset.
- select  in  2  source channel: 00 = ch0 (Caesar), 01 = ch1 (Scytale), 10 = ch2 (ZigZag), 11 = none.
- data0_i / valid0_i  in  SYS_DWIDTH / 1  Caesar decryptor character and strobe.
- data1_i / valid1_i  in  SYS_DWIDTH / 1  Scytale decryptor character and strobe.
- data2_i / valid2_i  in  SYS_DWIDTH / 1  ZigZag decryptor character and strobe.
- flush_i  in  1  emit the pending partial word.
- data_o  out  MST_DWIDTH  packed word; 0 whenever valid_o is low.
- valid_o  out  1  one-cycle pulse per emitted word.
- count_o  out  CW  number of valid characters in data_o (1..NBYTES); 0 whenever valid_o is low.

## Operation
- Internal state:
  - accumulator acc[MST_DWIDTH-1:0]
  - fill counter cnt (0..NBYTES-1)
  - registered select sel_q
- A character is accepted at a clk_sys edge when the valid of the channel named by `select` is high.
  - Strobes on unselected channels are ignored.
  - select = 11 accepts nothing.
- Lane placement, MSB first:
  - The k-th accepted character of a word (k = 0..NBYTES-1) is written to acc[MST_DWIDTH-1-k*SYS_DWIDTH -: SYS_DWIDTH].
  - The first character therefore lands in [31:24] and the fourth in [7:0].
- Full word: the edge that accepts character NBYTES-1 loads data_o with the completed word, sets valid_o = 1 and count_o = NBYTES, and clears cnt and acc.
- Flush: if flush_i is high at an edge and (cnt > 0 or a character is accepted), emit a partial word.
  - The partial word includes the character accepted on that same edge.
  - Unfilled lanes are 0 and count_o = filled lanes.
  - cnt and acc clear.
- Flush with cnt = 0 and no character accepted: no emission; flush_i is ignored.
- Flush on the edge that completes a word: normal full emission only; flush adds no extra pulse.
- Select change: if select != sel_q at an edge, the partial word is discarded (cnt and acc cleared) before capture.
  - A character accepted on that edge from the new channel becomes character 0.
  - A flush on that same edge applies only to that new character.
- sel_q <= select every edge.
- Reset (async, rst_n low) forces data_o = 0, valid_o = 0, count_o = 0, acc = 0, cnt = 0, sel_q = 00 immediately, independent of clk_sys. A partial word in progress is lost.

## Timing
- Latency: valid_o is high in the cycle after the edge that accepts the final character or samples flush_i.
- Throughput: one character per cycle sustained.
  - The character after a word's last one, on the next edge, becomes character 0 of the next word with no bubble.
  - Back-to-back words give valid_o high on every 4th cycle.
- Gaps: any number of idle cycles between characters is allowed; the partial word is held indefinitely.
- valid_o, data_o and count_o are all registered, with no combinational input-to-output path.
- All outputs are 0 from reset assertion until the first emission.

## Test plan
- Reset then select = 00, ch0 strobes 8'h41, 8'h42, 8'h43, 8'h44 on consecutive edges -> one cycle later: data_o = 32'h41424344, count_o = 4, valid_o high for exactly 1 cycle.
- select = 01, 8 consecutive ch1 characters 8'h01..8'h08 with ch0/ch2 strobing 8'hFF in the same cycles -> data_o = 32'h01020304, then 32'h05060708 four cycles later, with no 8'hFF anywhere.
- select = 10, ch2 sends 8'hAA, 8'hBB, idle 5 cycles, flush_i pulses -> data_o = 32'hAABB0000, count_o = 2. A second flush with nothing pending produces no pulse.
- select = 00, send 8'h11, 8'h22; switch select to 01 with ch1 sending 8'h33, then 8'h44, 8'h55, 8'h66 -> single emission data_o = 32'h33445566, count_o = 4 (8'h11 and 8'h22 discarded).
- select = 00, send 8'h10, 8'h20, 8'h30; fourth character 8'h40 arrives together with flush_i -> exactly one pulse, data_o = 32'h10203040, count_o = 4. Repeat with flush on the 3rd character -> data_o = 32'h10203000, count_o = 3.
- After 2 characters are accepted, assert rst_n low mid-cycle -> outputs are 0 immediately. After release, 4 new characters 8'hC1..8'hC4 -> data_o = 32'hC1C2C3C4 (no stale lanes).

Source files
------------

// File: rtl/mux_pack.sv
// Packs the selected decryptor's character stream into MST_DWIDTH words,
// first character in the most-significant lane, with flush of partial words.
module mux_pack #(
    parameter int MST_DWIDTH = 32,
    parameter int SYS_DWIDTH = 8
) (
    input  logic                                                 clk_sys,
    input  logic                                                 rst_n,
    input  logic [1:0]                                           select,
    input  logic [SYS_DWIDTH-1:0]                                data0_i,
    input  logic                                                 valid0_i,
    input  logic [SYS_DWIDTH-1:0]                                data1_i,
    input  logic                                                 valid1_i,
    input  logic [SYS_DWIDTH-1:0]                                data2_i,
    input  logic                                                 valid2_i,
    input  logic                                                 flush_i,
    output logic [MST_DWIDTH-1:0]                                data_o,
    output logic                                                 valid_o,
    output logic [$clog2(MST_DWIDTH/SYS_DWIDTH):0]               count_o
);

    localparam int NBYTES = MST_DWIDTH / SYS_DWIDTH;
    localparam int CW     = $clog2(NBYTES) + 1;

    logic [MST_DWIDTH-1:0] acc, acc_base, acc_nxt;
    logic [CW-1:0]         cnt, cnt_base, cnt_nxt;
    logic [1:0]            sel_q;
    logic                  sel_chg, accept, emit;
    logic [SYS_DWIDTH-1:0] ch;

    always_comb begin
        accept = 1'b0;
        ch     = '0;
        case (select)
            2'b00: begin accept = valid0_i; ch = data0_i; end
            2'b01: begin accept = valid1_i; ch = data1_i; end
            2'b10: begin accept = valid2_i; ch = data2_i; end
            default: begin accept = 1'b0; ch = '0; end
        endcase

        // A source switch drops the partial word before this edge's capture.
        sel_chg  = (select != sel_q);
        acc_base = sel_chg ? '0 : acc;
        cnt_base = sel_chg ? '0 : cnt;

        acc_nxt = acc_base;
        for (int k = 0; k < NBYTES; k++) begin
            if (accept && cnt_base == CW'(k))
                acc_nxt[MST_DWIDTH-1-k*SYS_DWIDTH -: SYS_DWIDTH] = ch;
        end
        cnt_nxt = cnt_base + CW'(accept);
        emit    = (cnt_nxt == CW'(NBYTES)) || (flush_i && cnt_nxt != '0);
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            sel_q   <= 2'b00;
            data_o  <= '0;
            valid_o <= 1'b0;
            count_o <= '0;
        end else begin
            sel_q <= select;
            if (emit) begin
                data_o  <= acc_nxt;
                count_o <= cnt_nxt;
                valid_o <= 1'b1;
                acc     <= '0;
                cnt     <= '0;
            end else begin
                data_o  <= '0;
                count_o <= '0;
                valid_o <= 1'b0;
                acc     <= acc_nxt;
                cnt     <= cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mux_pack.sv
// Randomized and directed stimulus for mux_pack; a queue-based character model
// feeds a scoreboard that a negedge monitor drains whenever valid_o is seen.
module tb_mux_pack;

    localparam int MW = 32;
    localparam int SW = 8;
    localparam int NB = MW / SW;
    localparam int CW = $clog2(NB) + 1;

    logic          clk_sys = 1'b0;
    logic          rst_n   = 1'b0;
    logic [1:0]    select  = 2'b00;
    logic [SW-1:0] data0_i = '0, data1_i = '0, data2_i = '0;
    logic          valid0_i = 1'b0, valid1_i = 1'b0, valid2_i = 1'b0;
    logic          flush_i = 1'b0;
    logic [MW-1:0] data_o;
    logic          valid_o;
    logic [CW-1:0] count_o;

    mux_pack #(.MST_DWIDTH(MW), .SYS_DWIDTH(SW)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .select(select),
        .data0_i(data0_i), .valid0_i(valid0_i),
        .data1_i(data1_i), .valid1_i(valid1_i),
        .data2_i(data2_i), .valid2_i(valid2_i),
        .flush_i(flush_i), .data_o(data_o), .valid_o(valid_o), .count_o(count_o)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct packed {
        logic [MW-1:0] data;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t          sb[$];
    logic [SW-1:0] mq[$];
    logic [1:0]    sel_m = 2'b00;
    int            vectors = 0;
    int            errors  = 0;

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: pending characters of the current word kept as a plain list.
    task automatic apply(input logic [1:0] s, input logic [2:0] v,
                         input logic [SW-1:0] d0, input logic [SW-1:0] d1,
                         input logic [SW-1:0] d2, input logic fl);
        logic [MW-1:0] word;
        logic [SW-1:0] d [3];
        select = s; flush_i = fl;
        valid0_i = v[0]; valid1_i = v[1]; valid2_i = v[2];
        data0_i = d0; data1_i = d1; data2_i = d2;
        d[0] = d0; d[1] = d1; d[2] = d2;
        if (s != sel_m) mq.delete();
        if (s != 2'b11 && v[int'(s)]) mq.push_back(d[int'(s)]);
        if (mq.size() == NB || (fl && mq.size() > 0)) begin
            word = '0;
            foreach (mq[k]) word[MW-1-k*SW -: SW] = mq[k];
            sb.push_back({word, CW'(mq.size())});
            mq.delete();
        end
        sel_m = s;
    endtask

    task automatic cyc(input logic [1:0] s, input logic [2:0] v,
                       input logic [SW-1:0] d0, input logic [SW-1:0] d1,
                       input logic [SW-1:0] d2, input logic fl);
        apply(s, v, d0, d1, d2, fl);
        @(negedge clk_sys);
    endtask

    task automatic idle(input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) cyc(s, 3'b000, '0, '0, '0, 1'b0);
    endtask

    // Reset pulse landing between edges, right after the edge that follows apply().
    task automatic reset_pulse(input bit exp_valid);
        @(posedge clk_sys);
        #1;
        if (exp_valid) chk("pre_reset_valid", MW'(valid_o), MW'(1));
        rst_n = 1'b0;
        #1;
        chk("rst_valid", MW'(valid_o), '0);
        chk("rst_data", data_o, '0);
        chk("rst_count", MW'(count_o), '0);
        sb.delete(); mq.delete(); sel_m = 2'b00;
        #1 rst_n = 1'b1;
        @(negedge clk_sys);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_sys);
            if (rst_n) begin
                if (valid_o) begin
                    if (sb.size() == 0) begin
                        vectors++; errors++;
                        $display("FAIL unexpected_word: got data %h count %0d, expected no valid", data_o, count_o);
                    end else begin
                        e = sb.pop_front();
                        chk("word_data", data_o, e.data);
                        chk("word_count", MW'(count_o), MW'(e.cnt));
                    end
                end else begin
                    chk("idle_data", data_o, '0);
                    chk("idle_count", MW'(count_o), '0);
                end
            end
        end
    end

    initial begin : stim
        logic [1:0] s;
        #3;
        chk("init_valid", MW'(valid_o), '0);
        chk("init_data", data_o, '0);
        chk("init_count", MW'(count_o), '0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        rst_n = 1'b1;
        idle(2'b00, 2);

        // full word from ch0
        cyc(2'b00, 3'b001, 8'h41, 0, 0, 0); cyc(2'b00, 3'b001, 8'h42, 0, 0, 0);
        cyc(2'b00, 3'b001, 8'h43, 0, 0, 0); cyc(2'b00, 3'b001, 8'h44, 0, 0, 0);
        idle(2'b00, 3);

        // ch1 selected while other channels strobe junk
        for (int i = 1; i <= 8; i++) cyc(2'b01, 3'b111, 8'hFF, SW'(i), 8'hFF, 0);
        idle(2'b01, 3);

        // partial word flush after a gap, then a flush with nothing pending
        cyc(2'b10, 3'b100, 0, 0, 8'hAA, 0); cyc(2'b10, 3'b100, 0, 0, 8'hBB, 0);
        idle(2'b10, 5);
        cyc(2'b10, 3'b000, 0, 0, 0, 1); idle(2'b10, 2);
        cyc(2'b10, 3'b000, 0, 0, 0, 1); idle(2'b10, 2);

        // select change discards the partial word
        cyc(2'b00, 3'b001, 8'h11, 0, 0, 0); cyc(2'b00, 3'b001, 8'h22, 0, 0, 0);
        cyc(2'b01, 3'b010, 0, 8'h33, 0, 0); cyc(2'b01, 3'b010, 0, 8'h44, 0, 0);
        cyc(2'b01, 3'b010, 0, 8'h55, 0, 0); cyc(2'b01, 3'b010, 0, 8'h66, 0, 0);
        idle(2'b01, 2);

        // flush on the completing character, then on the third
        cyc(2'b00, 3'b001, 8'h10, 0, 0, 0); cyc(2'b00, 3'b001, 8'h20, 0, 0, 0);
        cyc(2'b00, 3'b001, 8'h30, 0, 0, 0); cyc(2'b00, 3'b001, 8'h40, 0, 0, 1);
        idle(2'b00, 3);
        cyc(2'b00, 3'b001, 8'h10, 0, 0, 0); cyc(2'b00, 3'b001, 8'h20, 0, 0, 0);
        cyc(2'b00, 3'b001, 8'h30, 0, 0, 1);
        idle(2'b00, 3);

        // reset mid-word: no stale lanes afterwards
        cyc(2'b00, 3'b001, 8'hD1, 0, 0, 0); cyc(2'b00, 3'b001, 8'hD2, 0, 0, 0);
        apply(2'b00, 3'b000, 0, 0, 0, 0);
        reset_pulse(1'b0);
        cyc(2'b00, 3'b001, 8'hC1, 0, 0, 0); cyc(2'b00, 3'b001, 8'hC2, 0, 0, 0);
        cyc(2'b00, 3'b001, 8'hC3, 0, 0, 0); cyc(2'b00, 3'b001, 8'hC4, 0, 0, 0);
        idle(2'b00, 3);

        // reset while a word is being presented
        cyc(2'b00, 3'b001, 8'hE1, 0, 0, 0); cyc(2'b00, 3'b001, 8'hE2, 0, 0, 0);
        cyc(2'b00, 3'b001, 8'hE3, 0, 0, 0);
        apply(2'b00, 3'b001, 8'hE4, 0, 0, 0);
        reset_pulse(1'b1);
        idle(2'b00, 2);

        // random traffic
        s = 2'b00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(7) == 0) s = 2'($urandom_range(3));
            cyc(s, 3'($urandom_range(7)), 8'($urandom), 8'($urandom), 8'($urandom),
                1'($urandom_range(9) == 0));
        end
        idle(s, 4);

        chk("scoreboard_drained", MW'(sb.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
